// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL rst/locked sequencer with settle, timeout retry and lock-loss restart
// Optional macro PLL_SEQ_LOSS_FILTER_EN: RUN tolerates lock dropouts shorter than LOSS_FILTER cycles.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int LOSS_FILTER   = 4
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [1:0] state
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_SETTLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            sync1;
    logic            lk;
    logic            relock_inc;
    logic            lock_lost;

    // pll_locked is asynchronous to clk_74a
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

`ifdef PLL_SEQ_LOSS_FILTER_EN
    localparam int FW = $clog2(LOSS_FILTER + 1);
    localparam logic [FW-1:0] FILTER_LAST = FW'(LOSS_FILTER - 1);

    logic [FW-1:0] flt_q;
    logic [FW-1:0] flt_d;

    // Counter only runs while in RUN with lock low, so it is zero on RUN entry
    always_comb begin
        flt_d = '0;
        if (state_q == S_RUN && !lk) begin
            flt_d = flt_q + 1'b1;
        end
    end

    assign lock_lost = !lk && (flt_q == FILTER_LAST);

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            flt_q <= '0;
        end else begin
            flt_q <= flt_d;
        end
    end
`else
    logic [31:0] unused_loss_filter;
    assign unused_loss_filter = LOSS_FILTER;
    assign lock_lost          = !lk;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        relock_inc = 1'b0;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = S_RESET_PLL;
                    cnt_d      = '0;
                    relock_inc = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!lk) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (lock_lost) begin
                    state_d    = S_RESET_PLL;
                    relock_inc = 1'b1;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase
        // A restart request overrides everything and is not a relock
        if (req_reset) begin
            state_d    = S_RESET_PLL;
            cnt_d      = '0;
            relock_inc = 1'b0;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst      <= (state_d == S_RESET_PLL);
            core_reset_n <= (state_d == S_RUN);
            ready        <= (state_d == S_RUN);
            if (relock_inc && relock_count != 8'hFF) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer with a state-transition scoreboard
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int SETTLE_CYCLES = 8;
    localparam int LOSS_FILTER   = 3;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       req_reset;
    logic       pll_rst;
    logic       core_reset_n;
    logic       ready;
    logic [7:0] relock_count;
    logic [1:0] state;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] rc;
    } sb_t;

    sb_t        sb_q[$];
    int         tests  = 0;
    int         fails  = 0;
    logic       mon_en = 1'b0;
    logic [1:0] prev_state = 2'd0;

    pll_reset_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .LOSS_FILTER  (LOSS_FILTER)
    ) dut (
        .clk_74a     (clk_74a),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .req_reset   (req_reset),
        .pll_rst     (pll_rst),
        .core_reset_n(core_reset_n),
        .ready       (ready),
        .relock_count(relock_count),
        .state       (state)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic check(input string tag, input int got, input int exp_v);
        tests++;
        if (got != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [7:0] rc);
        sb_t e;
        e.st = st;
        e.rc = rc;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk_74a);
            #1;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int limit, output int n);
        n = 0;
        while (state != s && n < limit) begin
            @(posedge clk_74a);
            #1;
            n++;
        end
        if (state != s) check("timeout_state", int'(state), int'(s));
    endtask

    task automatic rst_hold(output int n);
        n = 0;
        while (pll_rst && n < 50) begin
            @(posedge clk_74a);
            #1;
            n++;
        end
    endtask

    task automatic pulse_req;
        req_reset = 1'b1;
        tick(1);
        req_reset = 1'b0;
    endtask

    // Every state change must match the next expected transition
    always @(negedge clk_74a) begin
        if (mon_en && state != prev_state) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", sb_q.size(), 1);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_state", int'(state), int'(e.st));
                check("sb_relock", int'(relock_count), int'(e.rc));
            end
        end
        prev_state <= state;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] rc_e;
        logic [7:0] rc_n;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        req_reset  = 1'b0;
        tick(3);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_core_reset_n", core_reset_n, 0);
        check("rst_ready", ready, 0);
        check("rst_relock", relock_count, 0);
        check("rst_state", state, 0);
        mon_en = 1'b1;

        // Power-up with lock arriving 10 cycles after reset release
        push(2'd1, 8'd0);
        push(2'd2, 8'd0);
        push(2'd3, 8'd0);
        reset_n = 1'b1;
        rst_hold(n);
        check("pwr_rst_hold", n, RST_CYCLES);
        check("pwr_wait_state", state, 1);
        tick(10 - RST_CYCLES);
        pll_locked = 1'b1;
        wait_state(2'd2, 20, n);
        check("pwr_lock_latency", n, 3);
        n = 0;
        while (!core_reset_n && n < 50) begin
            tick(1);
            n++;
        end
        check("pwr_settle_len", n, SETTLE_CYCLES);
        check("pwr_ready", ready, 1);
        check("pwr_relock", relock_count, 0);

        // One-cycle lock drop in SETTLE at cnt 5
        push(2'd0, 8'd0);
        push(2'd1, 8'd0);
        push(2'd2, 8'd0);
        push(2'd1, 8'd0);
        push(2'd2, 8'd0);
        push(2'd3, 8'd0);
        pulse_req();
        wait_state(2'd2, 40, n);
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_state(2'd1, 10, n);
        check("settle_drop_exit", n, 2);
        wait_state(2'd2, 10, n);
        check("settle_relock", n, 1);
        wait_state(2'd3, 30, n);
        check("settle_full_len", n, SETTLE_CYCLES);
        check("settle_relock_cnt", relock_count, 0);

`ifdef PLL_SEQ_LOSS_FILTER_EN
        // Short drop is filtered, a LOSS_FILTER-long drop restarts
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (!ready) n++;
        end
        check("filt_short_ready", n, 0);
        check("filt_short_state", state, 3);
        push(2'd0, 8'd1);
        push(2'd1, 8'd1);
        push(2'd2, 8'd1);
        push(2'd3, 8'd1);
        pll_locked = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        wait_state(2'd0, 10, n);
        check("filt_loss_latency", n + 3, 5);
        check("filt_loss_relock", relock_count, 1);
        wait_state(2'd3, 40, n);
`else
        // Single-cycle lock drop in RUN restarts
        push(2'd0, 8'd1);
        push(2'd1, 8'd1);
        push(2'd2, 8'd1);
        push(2'd3, 8'd1);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_state(2'd0, 10, n);
        check("run_loss_latency", n + 1, 3);
        rst_hold(n);
        check("run_loss_rst_hold", n, RST_CYCLES);
        check("run_loss_relock", relock_count, 1);
        wait_state(2'd3, 40, n);
`endif
        check("run_back_ready", ready, 1);

        // req_reset coincident with lock loss: one restart, no relock count
        push(2'd0, 8'd1);
        push(2'd1, 8'd1);
        push(2'd2, 8'd1);
        push(2'd3, 8'd1);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        pulse_req();
        check("coinc_state", state, 0);
        rst_hold(n);
        check("coinc_rst_hold", n, RST_CYCLES);
        check("coinc_relock", relock_count, 1);
        wait_state(2'd3, 40, n);

        // Asynchronous reset during SETTLE
        push(2'd0, 8'd1);
        push(2'd1, 8'd1);
        push(2'd2, 8'd1);
        push(2'd0, 8'd0);
        push(2'd1, 8'd0);
        push(2'd2, 8'd0);
        push(2'd3, 8'd0);
        pulse_req();
        wait_state(2'd2, 40, n);
        tick(2);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_pll_rst", pll_rst, 1);
        check("async_core_reset_n", core_reset_n, 0);
        check("async_ready", ready, 0);
        check("async_relock", relock_count, 0);
        check("async_state", state, 0);
        tick(1);
        reset_n = 1'b1;
        wait_state(2'd3, 60, n);

        // Lock never arrives: repeated timeouts saturate relock_count
        pll_locked = 1'b0;
        push(2'd0, 8'd0);
        pulse_req();
        rc_e = 8'd0;
        for (int i = 1; i <= 300; i++) begin
            rc_n = (rc_e == 8'hFF) ? 8'hFF : rc_e + 8'd1;
            push(2'd1, rc_e);
            push(2'd0, rc_n);
            wait_state(2'd1, 10, n);
            if (i <= 3) check("to_rst_hold", n, RST_CYCLES);
            wait_state(2'd0, 30, n);
            if (i <= 3) begin
                check("to_wait_len", n, LOCK_TIMEOUT);
                check("to_relock", relock_count, i);
                check("to_pll_rst", pll_rst, 1);
            end
            rc_e = rc_n;
        end
        check("to_relock_sat", relock_count, 255);
        tick(2);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
